pixel_readout: RTL and testbench

PIXEL_READOUT -- requirements
Module: pixel_readout

---
 rtl/pixel_readout_if.sv | 61 ++++++
 rtl/pixel_readout.sv | 210 +++++++++++++++++++++
 tb/tb_pixel_readout.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_if.sv
// ---------------------------------------------------------------------------
// pixel_readout_if
//
// Purpose : bundles the two handshakes of the frame reader: the image-RAM
//           read port and the outgoing pixel stream.
//
// Parameters
//   N          : image side length in pixels (frame is N*N, row-major)
//   bitSize    : RAM address width
//   pixelWidth : bits per pixel
//
// Signals
//   ram_re     : read enable to the image RAM (synchronous, 1-cycle latency)
//   ram_addr   : RAM read address
//   ram_data   : RAM read data, valid the cycle after ram_re
//   out_valid  : out_data holds a pixel
//   out_ready  : sink accepts the pixel
//   out_data   : pixel value
//   out_eol    : beat is the last pixel of a row
//   out_last   : beat is the last pixel of the frame
//
// Modports
//   master : the reader (drives the RAM request and the stream)
//   slave  : the environment (RAM model + stream sink)
// ---------------------------------------------------------------------------
interface pixel_readout_if #(
  parameter int N          = 8,
  parameter int bitSize    = $clog2(N*N),
  parameter int pixelWidth = 8
);
  logic                  ram_re;
  logic [bitSize-1:0]    ram_addr;
  logic [pixelWidth-1:0] ram_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [pixelWidth-1:0] out_data;
  logic                  out_eol;
  logic                  out_last;

  modport master (
    output ram_re,
    output ram_addr,
    input  ram_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_eol,
    output out_last
  );

  modport slave (
    input  ram_re,
    input  ram_addr,
    output ram_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_eol,
    input  out_last
  );
endinterface

// File: rtl/pixel_readout.sv
// ---------------------------------------------------------------------------
// pixel_readout
//
// Purpose : streams one N x N frame out of a synchronous-read image RAM as a
//           valid/ready pixel stream with end-of-row and end-of-frame flags.
//           A frame is requested with a start pulse; addresses 0..N*N-1 are
//           read exactly once each, in ascending order, and a one-cycle done
//           pulse follows the transfer of the last pixel.
//
// Ports
//   clk     : clock, all state on the rising edge
//   rst_n   : asynchronous active-low reset (aborts a frame in progress)
//   i_start : frame request, honoured only while idle
//   o_busy  : frame readout in progress
//   o_done  : one-cycle pulse after the last pixel has transferred
//   bus     : pixel_readout_if.master (RAM read port + pixel stream)
//
// Configuration
//   PIXEL_READOUT_BINARIZE_EN : when defined, every nonzero RAM pixel is
//                               emitted as all-ones and zero stays zero.
//                               Timing is identical with or without it.
//
// Pipeline: read request (cycle c) -> RAM data (cycle c+1) -> 2-entry output
// buffer (captured at the end of cycle c+1). The read request is decided
// combinationally from the buffer occupancy and the current out_ready so
// that a pixel leaving the buffer frees its slot on the same edge; this is
// what allows one pixel per cycle with only two entries of storage.
// ---------------------------------------------------------------------------
module pixel_readout #(
  parameter int N          = 8,
  parameter int bitSize    = $clog2(N*N),
  parameter int pixelWidth = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  pixel_readout_if.master bus
);

  localparam int                 NPIX     = N * N;
  localparam logic [bitSize-1:0] LAST_IDX = bitSize'(NPIX - 1);
  localparam int                 COLW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [COLW-1:0]    LAST_COL = COLW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Control state
  state_t              r_state;
  logic                r_busy;
  logic                r_done;

  // Read side: next address to request, and a flag once the final address
  // has gone out (the address register is already back at 0 by then).
  logic [bitSize-1:0]  r_rd_addr;
  logic                r_rd_all;

  // One read in flight: its data is on ram_data during this cycle.
  logic                r_inflight;

  // Output buffer (2 entries, circular)
  logic [pixelWidth-1:0] r_buf [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  // Output side: frame index and column of the pixel at the buffer head
  logic [bitSize-1:0]  r_out_idx;
  logic [COLW-1:0]     r_out_col;

  logic                  w_out_valid;
  logic                  w_xfer;
  logic                  w_issue;
  logic [1:0]            w_occupancy;
  logic [pixelWidth-1:0] w_pix;

  assign w_out_valid = (r_count != 2'd0);
  assign w_xfer      = w_out_valid && bus.out_ready;

  // Pixels that already own a buffer slot: stored ones plus the one whose
  // data is arriving now. Never exceeds 2 by construction.
  assign w_occupancy = r_count + {1'b0, r_inflight};

  // A new read may only be issued if its data is guaranteed a slot when it
  // lands, counting a slot freed by a transfer on this same edge.
  assign w_issue = (r_state == STREAM) && !r_rd_all &&
                   ((w_occupancy < 2'd2) ||
                    ((w_occupancy == 2'd2) && w_xfer));

`ifdef PIXEL_READOUT_BINARIZE_EN
  assign w_pix = (bus.ram_data != '0) ? '1 : '0;
`else
  assign w_pix = bus.ram_data;
`endif

  // -------------------------------------------------------------------------
  // Control FSM: frame sequencing, read address counter, output indexing.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_addr <= '0;
      r_rd_all  <= 1'b0;
      r_out_idx <= '0;
      r_out_col <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state   <= STREAM;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
            r_out_idx <= '0;
            r_out_col <= '0;
          end
        end

        STREAM: begin
          // Compare against the last address before incrementing so the
          // counter never runs past the frame; it parks at 0 for next time.
          if (w_issue) begin
            if (r_rd_addr == LAST_IDX) begin
              r_rd_addr <= '0;
              r_rd_all  <= 1'b1;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end

          if (w_xfer) begin
            if (r_out_idx == LAST_IDX) begin
              r_state   <= DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_out_idx <= '0;
              r_out_col <= '0;
            end else begin
              r_out_idx <= r_out_idx + 1'b1;
              r_out_col <= (r_out_col == LAST_COL) ? '0 : r_out_col + 1'b1;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline and output buffer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= w_issue;

      if (r_inflight) begin
        r_buf[r_wr_ptr] <= w_pix;
        r_wr_ptr        <= ~r_wr_ptr;
      end

      if (w_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Stream fields are forced to 0 when no pixel is held; while a
  // pixel waits for out_ready the head pointer and indices do not move, so
  // data and flags stay stable.
  // -------------------------------------------------------------------------
  assign bus.ram_re    = w_issue;
  assign bus.ram_addr  = r_rd_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_buf[r_rd_ptr] : '0;
  assign bus.out_eol   = w_out_valid && (r_out_col == LAST_COL);
  assign bus.out_last  = w_out_valid && (r_out_idx == LAST_IDX);

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_pixel_readout.sv
// ---------------------------------------------------------------------------
// tb_pixel_readout
//
// Bench for pixel_readout (N=8, 8-bit pixels). A RAM model answers reads one
// cycle late. The reference is kept at frame level: the k-th accepted beat
// must carry image[k] (binarized when PIXEL_READOUT_BINARIZE_EN is defined)
// with eol = (k mod 8 == 7) and last = (k == 63); reads must walk 0..63.
// Inputs change 2 time units after the rising edge, outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_pixel_readout;
  localparam int N    = 8;
  localparam int NPIX = N * N;
  localparam int AW   = 6;
  localparam int PW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  pixel_readout_if #(.N(N), .bitSize(AW), .pixelWidth(PW)) bus ();

  pixel_readout #(.N(N), .bitSize(AW), .pixelWidth(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Image RAM, synchronous read
  logic [PW-1:0] mem [NPIX];
  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_data <= mem[bus.ram_addr];
  end

  typedef struct {
    int ready_mode;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int img_mode;     // 0: image[i]=i, 1: random
    int restart_at;   // beat index at which start is re-pulsed, -1 none
    int exp_beats;
    int exp_dones;
    int exp_done_cyc; // 0 = not checked
  } vec_t;

  vec_t vecs [6];

  int n_total, n_pass;
  int cyc, mode;
  int exp_idx, exp_addr, beat_total, done_cnt;
  int first_re, first_valid, done_cyc, busy_c0;
  logic          prev_stall;
  logic [PW+1:0] prev_beat;
  logic [PW-1:0] got_pix [2];
  logic [3:0]    rdy_pat;

  function automatic logic [PW-1:0] ref_pix(input logic [PW-1:0] v);
`ifdef PIXEL_READOUT_BINARIZE_EN
    return (v != '0) ? {PW{1'b1}} : '0;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  task automatic load_img(input int m);
    for (int i = 0; i < NPIX; i++) begin
      if (m == 0) mem[i] = PW'(i);
      else if ($urandom_range(0, 3) == 0) mem[i] = '0;
      else mem[i] = PW'($urandom_range(1, 255));
    end
  endtask

  // Called at the falling edge: compare outputs with the frame-level model.
  task automatic sample();
    logic [PW-1:0] ev;
    logic          eeol, elast, inr;
    if (!rst_n) begin
      chk("reset_outputs", int'({bus.ram_re, bus.ram_addr, bus.out_valid, bus.out_data,
                                 bus.out_eol, bus.out_last, busy, done}), 0);
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall)
      chk("stall_hold", int'({bus.out_valid, bus.out_data, bus.out_eol, bus.out_last}),
          int'({1'b1, prev_beat}));
    if (!bus.out_valid)
      chk("idle_flags", int'({bus.out_eol, bus.out_last}), 0);
    if (bus.ram_re) begin
      chk("rd_addr", int'(bus.ram_addr), exp_addr);
      exp_addr++;
      if (first_re < 0) first_re = cyc;
    end
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (cyc == 0) busy_c0 = int'(busy);
    if (bus.out_valid && bus.out_ready) begin
      inr   = (exp_idx < NPIX);
      ev    = inr ? ref_pix(mem[exp_idx]) : '0;
      eeol  = (exp_idx % N) == (N - 1);
      elast = (exp_idx == NPIX - 1);
      chk("beat", int'({1'b1, bus.out_data, bus.out_eol, bus.out_last}),
          int'({inr, ev, eeol, elast}));
      if (exp_idx < 2) got_pix[exp_idx] = bus.out_data;
      exp_idx++;
      beat_total++;
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_beat  = {bus.out_data, bus.out_eol, bus.out_last};
    if (done) begin
      chk("done_after_last", exp_idx, NPIX);
      chk("done_not_busy", int'(busy), 0);
      done_cnt++;
      done_cyc = cyc;
      exp_idx  = 0;
      exp_addr = 0;
    end
  endtask

  // One clock cycle: set out_ready, sample at the falling edge, advance.
  task automatic step();
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = rdy_pat[cyc % 4];
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
    sample();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic pulse_start();
    first_re    = -1;
    first_valid = -1;
    busy_c0     = -1;
    done_cyc    = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_frame(input int ready_mode, input int restart_at,
                           output int beats, output int dones);
    int b0, d0;
    logic pulsed;
    mode   = ready_mode;
    b0     = beat_total;
    d0     = done_cnt;
    pulsed = 1'b0;
    pulse_start();
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      if (restart_at >= 0 && !pulsed && exp_idx >= restart_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      n_total++;
      $display("FAIL frame_timeout: no done within 3000 cycles, beats=%0d", beat_total - b0);
    end
    repeat (4) step();
    beats = beat_total - b0;
    dones = done_cnt - d0;
  endtask

  initial begin
    int beats, dones, d0, b0;
    vecs[0] = '{0, 0, -1, 64, 1, 66};
    vecs[1] = '{1, 0, -1, 64, 1, 0};
    vecs[2] = '{0, 0, 10, 64, 1, 66};
    vecs[3] = '{2, 1, -1, 64, 1, 0};
    vecs[4] = '{2, 1, 30, 64, 1, 0};
    vecs[5] = '{1, 1, -1, 64, 1, 0};

    n_total = 0; n_pass = 0; cyc = 0; mode = 0;
    exp_idx = 0; exp_addr = 0; beat_total = 0; done_cnt = 0;
    prev_stall = 1'b0; prev_beat = '0; rdy_pat = 4'b1001;
    got_pix[0] = '0; got_pix[1] = '0;
    rst_n = 1'b0; start = 1'b0; bus.out_ready = 1'b1;
    load_img(0);

    // Reset state
    @(posedge clk); #2;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      load_img(vecs[v].img_mode);
      run_frame(vecs[v].ready_mode, vecs[v].restart_at, beats, dones);
      $display("frame %0d: ready_mode=%0d restart_at=%0d beats=%0d dones=%0d done_cyc=%0d",
               v, vecs[v].ready_mode, vecs[v].restart_at, beats, dones, done_cyc);
      chk("frame_beats", beats, vecs[v].exp_beats);
      chk("frame_dones", dones, vecs[v].exp_dones);
      if (vecs[v].exp_done_cyc != 0) begin
        chk("first_read_cycle", first_re, 0);
        chk("first_valid_cycle", first_valid, 2);
        chk("busy_after_start", busy_c0, 1);
        chk("done_cycle", done_cyc, vecs[v].exp_done_cyc);
      end
    end

    // Reset in the middle of a frame (at pixel 20), then a fresh frame
    load_img(0);
    mode = 0;
    pulse_start();
    for (int k = 0; k < 500 && exp_idx < 20; k++) step();
    if (exp_idx < 20) begin
      n_total++;
      $display("FAIL abort_reach_20: only %0d beats seen", exp_idx);
    end
    rst_n    = 1'b0;
    exp_idx  = 0;
    exp_addr = 0;
    d0       = done_cnt;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    $display("abort: reset held 2 cycles, dones during abort=%0d", done_cnt - d0);
    chk("abort_no_done", done_cnt, d0);
    run_frame(0, -1, beats, dones);
    $display("after abort: beats=%0d dones=%0d", beats, dones);
    chk("abort_restart_beats", beats, 64);
    chk("abort_restart_dones", dones, 1);

    // Binarize corner: pixel 0 = 0x01, pixel 1 = 0x00
    load_img(1);
    mem[0] = 8'h01;
    mem[1] = 8'h00;
    run_frame(1, -1, beats, dones);
    $display("binarize: pix0=0x%0h pix1=0x%0h beats=%0d", got_pix[0], got_pix[1], beats);
`ifdef PIXEL_READOUT_BINARIZE_EN
    chk("bin_pix0", int'(got_pix[0]), 255);
`else
    chk("bin_pix0", int'(got_pix[0]), 1);
`endif
    chk("bin_pix1", int'(got_pix[1]), 0);

    // Back-to-back frames: second start in the cycle right after done
    load_img(1);
    mode = 0;
    d0 = done_cnt;
    b0 = beat_total;
    pulse_start();
    for (int k = 0; k < 500 && done_cnt == d0; k++) step();
    pulse_start();
    for (int k = 0; k < 500 && done_cnt < d0 + 2; k++) step();
    repeat (4) step();
    $display("back-to-back: beats=%0d dones=%0d", beat_total - b0, done_cnt - d0);
    chk("b2b_beats", beat_total - b0, 128);
    chk("b2b_dones", done_cnt - d0, 2);
    chk("b2b_done_cycle", done_cyc, 66);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
